freq_meter: RTL and testbench

FREQ_METER -- requirements
Module: freq_meter

---
 rtl/freq_meter.sv | 157 +++++++++++++++
 tb/tb_freq_meter.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_meter.sv
// freq_meter: counts clk cycles spanned by 2^LOG_N periods of sig_in.
// Ports: clk, rst_n, start, sig_in, res_ready in; res_valid, period, overflow, busy out.
module freq_meter #(
  parameter int WIDTH = 16,
  parameter int LOG_N = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sig_in,
  input  logic             res_ready,
  output logic             res_valid,
  output logic [WIDTH-1:0] period,
  output logic             overflow,
  output logic             busy
);

  localparam int EW = LOG_N + 1;
  localparam logic [EW-1:0] LAST = EW'((1 << LOG_N) - 1);
  localparam logic [WIDTH-1:0] MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_MEAS,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic             r_s1;
  logic             r_s2;
  logic             r_s3;
  logic             r_edge;
  logic [WIDTH-1:0] r_cnt;
  logic [EW-1:0]    r_ecnt;
  logic [WIDTH-1:0] r_period;
  logic             r_ovf;

  logic w_sat;
  logic w_last;
  logic w_clr_arm;
  logic w_clr_t0;
  logic w_load;
  logic w_load_ovf;

  // 2-flop synchronizer plus a registered rising-edge pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_s3   <= 1'b0;
      r_edge <= 1'b0;
    end else begin
      r_s1   <= sig_in;
      r_s2   <= r_s1;
      r_s3   <= r_s2;
      r_edge <= r_s2 & ~r_s3;
    end
  end

  assign w_sat  = (r_cnt == MAX);
  assign w_last = r_edge && (r_ecnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_clr_arm  = 1'b0;
    w_clr_t0   = 1'b0;
    w_load     = 1'b0;
    w_load_ovf = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next    = S_ARM;
          w_clr_arm = 1'b1;
        end
      end
      S_ARM: begin
        if (r_edge) begin
          w_next   = S_MEAS;
          w_clr_t0 = 1'b1;
        end else if (w_sat) begin
          w_next     = S_DONE;
          w_load     = 1'b1;
          w_load_ovf = 1'b1;
        end
      end
      S_MEAS: begin
        // The final edge takes priority over saturation.
        if (w_last) begin
          w_next = S_DONE;
          w_load = 1'b1;
        end else if (w_sat) begin
          w_next     = S_DONE;
          w_load     = 1'b1;
          w_load_ovf = 1'b1;
        end
      end
      S_DONE: begin
        if (res_ready) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Cycle t0 itself counts as 0, so the first MEASURE cycle holds 1
  // and the counter equals tN - t0 on the final edge.
  // The counter parks at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_clr_arm) begin
      r_cnt <= '0;
    end else if (w_clr_t0) begin
      r_cnt <= WIDTH'(1);
    end else if (busy && !w_sat) begin
      r_cnt <= r_cnt + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ecnt <= '0;
    end else if (w_clr_arm || w_clr_t0) begin
      r_ecnt <= '0;
    end else if (r_state == S_MEAS && r_edge && !w_last) begin
      r_ecnt <= r_ecnt + EW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_period <= '0;
      r_ovf    <= 1'b0;
    end else if (w_load) begin
      r_period <= w_load_ovf ? MAX : r_cnt;
      r_ovf    <= w_load_ovf;
    end
  end

  assign res_valid = (r_state == S_DONE);
  assign busy      = (r_state == S_ARM) || (r_state == S_MEAS);
  assign period    = r_period;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: directed checks of freq_meter in three configurations.
// u_a: 16/0, u_b: 16/2, u_c: 8/0; sig_in driven by a per-DUT square wave.
module tb_freq_meter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  st;
  logic [2:0]  sg;
  logic [2:0]  rr;
  logic [2:0]  rv;
  logic [2:0]  ov;
  logic [2:0]  bz;
  logic [15:0] pa;
  logic [15:0] pb;
  logic [7:0]  pc;
  logic [15:0] po [3];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int g_per  [3] = '{1, 1, 1};
  int g_base [3] = '{0, 0, 0};
  bit g_en   [3] = '{0, 0, 0};
  bit g_lvl  [3] = '{0, 0, 0};

  always #5 clk = ~clk;

  assign po[0] = pa;
  assign po[1] = pb;
  assign po[2] = {8'h00, pc};

  freq_meter #(.WIDTH(16), .LOG_N(0)) u_a (
    .clk(clk), .rst_n(rst_n), .start(st[0]),
    .sig_in(sg[0]), .res_ready(rr[0]),
    .res_valid(rv[0]), .period(pa),
    .overflow(ov[0]), .busy(bz[0])
  );

  freq_meter #(.WIDTH(16), .LOG_N(2)) u_b (
    .clk(clk), .rst_n(rst_n), .start(st[1]),
    .sig_in(sg[1]), .res_ready(rr[1]),
    .res_valid(rv[1]), .period(pb),
    .overflow(ov[1]), .busy(bz[1])
  );

  freq_meter #(.WIDTH(8), .LOG_N(0)) u_c (
    .clk(clk), .rst_n(rst_n), .start(st[2]),
    .sig_in(sg[2]), .res_ready(rr[2]),
    .res_valid(rv[2]), .period(pc),
    .overflow(ov[2]), .busy(bz[2])
  );

  // Square-wave sources, updated just after each falling edge.
  initial begin
    sg = '0;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      for (int i = 0; i < 3; i++) begin
        if (g_en[i])
          sg[i] = ((cyc - g_base[i]) % g_per[i]) < (g_per[i] / 2);
        else
          sg[i] = g_lvl[i];
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic hold(input int i, input bit lvl);
    g_en[i]  = 1'b0;
    g_lvl[i] = lvl;
  endtask

  // Phase p is the wave position on the next generator update.
  task automatic cfg(input int i, input int per, input int p);
    g_per[i]  = per;
    g_base[i] = cyc + 1 - p;
    g_en[i]   = 1'b1;
  endtask

  // Quiet the source, then restart at the beginning of its low half.
  task automatic clean_cfg(input int i, input int per);
    hold(i, 1'b0);
    cycles(8);
    cfg(i, per, per / 2);
  endtask

  task automatic pulse_start(input int i);
    @(negedge clk);
    st[i] = 1'b1;
    @(negedge clk);
    st[i] = 1'b0;
  endtask

  task automatic wait_valid(input int i, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (rv[i] === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic ack(input int i);
    @(negedge clk);
    rr[i] = 1'b1;
    @(negedge clk);
    rr[i] = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (rv[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_valid[%0d]: got %b want 0", i, rv[i]);
      end
      n_tests++;
      if (ov[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_ovf[%0d]: got %b want 0", i, ov[i]);
      end
      n_tests++;
      if (bz[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_busy[%0d]: got %b want 0", i, bz[i]);
      end
      n_tests++;
      if (po[i] !== 16'd0) begin
        n_fail++;
        $display("FAIL reset_period[%0d]: got %0h want 0", i, po[i]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    bit ok;
    clean_cfg(0, 16);
    pulse_start(0);
    n_tests++;
    if (bz[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_busy_arm: got %b want 1", bz[0]);
    end
    wait_valid(0, 200, ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL basic_timeout: valid %b want 1", rv[0]);
    end
    n_tests++;
    if (po[0] !== 16'd16) begin
      n_fail++;
      $display("FAIL basic_period: got %0d want 16", po[0]);
    end
    n_tests++;
    if (ov[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_ovf: got %b want 0", ov[0]);
    end
    n_tests++;
    if (bz[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_busy_done: got %b want 0", bz[0]);
    end
    ack(0);
    n_tests++;
    if (rv[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_valid_drop: got %b want 0", rv[0]);
    end
  endtask

  task automatic test_hold();
    bit ok;
    clean_cfg(1, 10);
    pulse_start(1);
    wait_valid(1, 300, ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL hold_timeout: valid %b want 1", rv[1]);
    end
    n_tests++;
    if (po[1] !== 16'd40 || ov[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_result: got %0d/%b want 40/0", po[1], ov[1]);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_tests++;
      if (rv[1] !== 1'b1) begin
        n_fail++;
        $display("FAIL hold_valid[%0d]: got %b want 1", k, rv[1]);
      end
      n_tests++;
      if (po[1] !== 16'd40) begin
        n_fail++;
        $display("FAIL hold_period[%0d]: got %0d want 40", k, po[1]);
      end
    end
    ack(1);
    n_tests++;
    if (rv[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_valid_drop: got %b want 0", rv[1]);
    end
  endtask

  task automatic test_overflow();
    bit ok;
    hold(2, 1'b0);
    pulse_start(2);
    cycles(100);
    n_tests++;
    if (bz[2] !== 1'b1 || rv[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_arm: busy/valid %b/%b want 1/0", bz[2], rv[2]);
    end
    wait_valid(2, 400, ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL ovf_timeout: valid %b want 1", rv[2]);
    end
    n_tests++;
    if (po[2] !== 16'h00FF) begin
      n_fail++;
      $display("FAIL ovf_period: got %0h want ff", po[2]);
    end
    n_tests++;
    if (ov[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_flag: got %b want 1", ov[2]);
    end
    n_tests++;
    if (bz[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_busy: got %b want 0", bz[2]);
    end
    ack(2);
  endtask

  task automatic test_sat_edge();
    bit ok;
    int         pers [3] = '{255, 256, 254};
    logic [7:0] ep   [3] = '{8'hFF, 8'hFF, 8'hFE};
    bit         eo   [3] = '{1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 3; k++) begin
      clean_cfg(2, pers[k]);
      pulse_start(2);
      wait_valid(2, 700, ok);
      n_tests++;
      if (!ok) begin
        n_fail++;
        $display("FAIL sat_timeout[%0d]: valid %b want 1", pers[k], rv[2]);
      end
      n_tests++;
      if (po[2] !== {8'h00, ep[k]} || ov[2] !== eo[k]) begin
        n_fail++;
        $display("FAIL sat_result[%0d]: got %0h/%b want %0h/%b",
                 pers[k], po[2], ov[2], ep[k], eo[k]);
      end
      ack(2);
    end
  endtask

  task automatic test_high_start();
    bit ok;
    hold(0, 1'b1);
    cycles(8);
    cfg(0, 8, 1);
    st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    wait_valid(0, 100, ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL high_timeout: valid %b want 1", rv[0]);
    end
    n_tests++;
    if (po[0] !== 16'd8 || ov[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL high_result: got %0d/%b want 8/0", po[0], ov[0]);
    end
    ack(0);
  endtask

  task automatic test_reset_mid();
    bit ok;
    clean_cfg(0, 32);
    pulse_start(0);
    cycles(30);
    n_tests++;
    if (bz[0] !== 1'b1 || po[0] !== 16'd8) begin
      n_fail++;
      $display("FAIL mid_busy: busy/period %b/%0d want 1/8", bz[0], po[0]);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (rv[0] !== 1'b0 || ov[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rst_flags: valid/ovf %b/%b want 0/0", rv[0], ov[0]);
    end
    n_tests++;
    if (bz[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rst_busy: got %b want 0", bz[0]);
    end
    n_tests++;
    if (po[0] !== 16'd0) begin
      n_fail++;
      $display("FAIL mid_rst_period: got %0d want 0", po[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cycles(10);
    n_tests++;
    if (bz[0] !== 1'b0 || rv[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_idle: busy/valid %b/%b want 0/0", bz[0], rv[0]);
    end
    pulse_start(0);
    wait_valid(0, 200, ok);
    n_tests++;
    if (!ok || po[0] !== 16'd32 || ov[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rerun: ok/period/ovf %b/%0d/%b want 1/32/0",
               ok, po[0], ov[0]);
    end
    ack(0);
  endtask

  task automatic test_ignored_start();
    bit ok;
    bit bad;
    clean_cfg(0, 16);
    pulse_start(0);
    cycles(18);
    pulse_start(0);
    n_tests++;
    if (bz[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL ign_busy: got %b want 1", bz[0]);
    end
    wait_valid(0, 100, ok);
    n_tests++;
    if (!ok || po[0] !== 16'd16) begin
      n_fail++;
      $display("FAIL ign_result: ok/period %b/%0d want 1/16", ok, po[0]);
    end
    @(negedge clk);
    rr[0] = 1'b1;
    st[0] = 1'b1;
    @(negedge clk);
    rr[0] = 1'b0;
    st[0] = 1'b0;
    n_tests++;
    if (rv[0] !== 1'b0 || bz[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL ign_hs: valid/busy %b/%b want 0/0", rv[0], bz[0]);
    end
    bad = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (rv[0] !== 1'b0 || bz[0] !== 1'b0) bad = 1'b1;
    end
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL ign_idle: left IDLE got 1 want 0");
    end
  endtask

  initial begin
    rst_n = 1'b0;
    st    = '0;
    rr    = '0;
    test_reset();
    test_basic();
    test_hold();
    test_overflow();
    test_sat_edge();
    test_high_start();
    test_reset_mid();
    test_ignored_start();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
